// File: rtl/store_buffer_if.sv
// store_buffer_if: CPU-side store/load signals and data-memory drain signals of the store buffer.
// Signals: memwrite/memaddr/memwritedata/memreaddata (CPU), dm_raddr/dm_rdata (async DM read),
// dm_req/dm_ack/dm_waddr/dm_wdata (drain write), full/empty/overflow (status).
interface store_buffer_if;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic [31:0] dm_raddr;
  logic [31:0] dm_rdata;
  logic        dm_req;
  logic        dm_ack;
  logic [31:0] dm_waddr;
  logic [31:0] dm_wdata;
  logic        full;
  logic        empty;
  logic        overflow;
  modport slave (
    input  memwrite, memaddr, memwritedata, dm_rdata, dm_ack,
    output memreaddata, dm_raddr, dm_req, dm_waddr, dm_wdata, full, empty, overflow
  );
  modport master (
    output memwrite, memaddr, memwritedata, dm_rdata, dm_ack,
    input  memreaddata, dm_raddr, dm_req, dm_waddr, dm_wdata, full, empty, overflow
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: DEPTH-entry circular FIFO of word stores drained to data memory via dm_req/dm_ack.
// Ports: clk, reset (async active-low), bus (store_buffer_if.slave).
// Optional store-to-load forwarding enabled by defining STORE_BUFFER_FWD_EN.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);
  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, full, empty;
  assign full  = count_q == CNT_MAX;
  assign empty = count_q == '0;
  always_comb begin
    pop        = ~empty & bus.dm_ack;
    push       = bus.memwrite & (~full | pop);
    head_d     = head_q + AW'(pop);
    tail_d     = tail_q + AW'(push);
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    overflow_d = overflow_q | (bus.memwrite & ~push);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.memaddr[31:2];
      data_q[tail_q] <= bus.memwritedata;
    end
  end
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = overflow_q;
  assign bus.dm_req   = ~empty;
  assign bus.dm_waddr = {addr_q[head_q], 2'b00};
  assign bus.dm_wdata = data_q[head_q];
  assign bus.dm_raddr = bus.memaddr;
`ifdef STORE_BUFFER_FWD_EN
  logic [AW-1:0] idx;
  logic [31:0]   fwd;
  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    fwd = bus.dm_rdata;
    idx = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if ((AW+1)'(i) < count_q && addr_q[idx] == bus.memaddr[31:2]) fwd = data_q[idx];
    end
  end
  assign bus.memreaddata = fwd;
`else
  assign bus.memreaddata = bus.dm_rdata;
`endif
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer (DEPTH=4).
module tb_store_buffer;
  localparam int DEPTH = 4;
`ifdef STORE_BUFFER_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q [$];
  logic exp_ovf = 1'b0;
  store_buffer_if sb_if ();
  store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(sb_if.slave));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (reset && sb_if.dm_req === 1'b1 && sb_if.dm_ack === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL drain_write: unexpected write addr=%h data=%h, none required", sb_if.dm_waddr, sb_if.dm_wdata);
      end else begin
        if ({sb_if.dm_waddr, sb_if.dm_wdata} !== exp_q[0]) begin
          fails++;
          $display("FAIL drain_write: got %h/%h required %h/%h", sb_if.dm_waddr, sb_if.dm_wdata, exp_q[0][63:32], exp_q[0][31:0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end
  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d, input logic ack);
    int n;
    n = exp_q.size();
    if (we && (n < DEPTH || (ack && n != 0))) exp_q.push_back({a[31:2], 2'b00, d});
    else if (we) exp_ovf = 1'b1;
    sb_if.memwrite = we;
    sb_if.memaddr = a;
    sb_if.memwritedata = d;
    sb_if.dm_ack = ack;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    sb_if.memwrite = 1'b0;
    sb_if.dm_ack = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(1'b0, 32'h0, 32'h0, 1'b1);
    tests++;
    if (exp_q.size() != 0 || sb_if.empty !== 1'b1) begin
      fails++;
      $display("FAIL drain_done: empty=%b pending=%0d, required empty=1 pending=0", sb_if.empty, exp_q.size());
    end
  endtask
  task automatic test_reset();
    reset = 1'b0;
    #2;
    tests++;
    if ({sb_if.empty, sb_if.full, sb_if.dm_req, sb_if.overflow} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_state: empty/full/req/ovf=%b required 1000", {sb_if.empty, sb_if.full, sb_if.dm_req, sb_if.overflow});
    end
    do_reset();
  endtask
  task automatic test_single();
    drive(1'b1, 32'h10, 32'hAAAA0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({sb_if.empty, sb_if.dm_req, sb_if.dm_waddr, sb_if.dm_wdata} !== {1'b0, 1'b1, 32'h10, 32'hAAAA0001}) begin
        fails++;
        $display("FAIL single_hold%0d: empty=%b req=%b waddr=%h wdata=%h required 0 1 00000010 aaaa0001", i, sb_if.empty, sb_if.dm_req, sb_if.dm_waddr, sb_if.dm_wdata);
      end
      if (i < 3) drive(1'b0, 32'h0, 32'h0, 1'b0);
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1);
    tests++;
    if (sb_if.empty !== 1'b1) begin
      fails++;
      $display("FAIL single_drained: empty=%b required 1", sb_if.empty);
    end
    sb_if.dm_ack = 1'b0;
  endtask
  task automatic test_overflow();
    logic [31:0] addrs [5];
    addrs = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h20};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, addrs[i], 32'h100 + i, 1'b0);
      tests++;
      if (sb_if.full !== (i >= 3)) begin
        fails++;
        $display("FAIL overflow_full%0d: full=%b required %b", i, sb_if.full, i >= 3);
      end
    end
    tests++;
    if (sb_if.overflow !== 1'b1 || exp_ovf !== 1'b1) begin
      fails++;
      $display("FAIL overflow_flag: overflow=%b required 1", sb_if.overflow);
    end
    drain();
    tests++;
    if (sb_if.overflow !== 1'b1) begin
      fails++;
      $display("FAIL overflow_sticky: overflow=%b required 1", sb_if.overflow);
    end
    do_reset();
  endtask
  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h80 + 4 * i, 32'h200 + i, 1'b0);
    drive(1'b1, 32'h40, 32'h5, 1'b1);
    tests++;
    if ({sb_if.full, sb_if.overflow} !== 2'b10) begin
      fails++;
      $display("FAIL full_push_pop: full=%b overflow=%b required 1 0", sb_if.full, sb_if.overflow);
    end
    tests++;
    if (exp_q.size() != 4 || exp_q[3] !== {32'h40, 32'h5}) begin
      fails++;
      $display("FAIL full_push_pop_model: pending=%0d required 4 with 0x40 last", exp_q.size());
    end
    drain();
  endtask
  task automatic test_forward();
    drive(1'b1, 32'h8, 32'h1, 1'b0);
    drive(1'b1, 32'h8, 32'h2, 1'b0);
    sb_if.memwrite = 1'b0;
    sb_if.dm_rdata = 32'hDEAD;
    sb_if.memaddr = 32'h8;
    #1;
    tests++;
    if (sb_if.memreaddata !== (FWD ? 32'h2 : 32'hDEAD)) begin
      fails++;
      $display("FAIL fwd_hit: memreaddata=%h required %h", sb_if.memreaddata, FWD ? 32'h2 : 32'hDEAD);
    end
    sb_if.memaddr = 32'hC;
    #1;
    tests++;
    if (sb_if.memreaddata !== 32'hDEAD || sb_if.dm_raddr !== 32'hC) begin
      fails++;
      $display("FAIL fwd_miss: memreaddata=%h raddr=%h required dead 0000000c", sb_if.memreaddata, sb_if.dm_raddr);
    end
    sb_if.memaddr = 32'h10;
    sb_if.memwritedata = 32'h7;
    sb_if.memwrite = 1'b1;
    exp_q.push_back({32'h10, 32'h7});
    #1;
    tests++;
    if (sb_if.memreaddata !== 32'hDEAD) begin
      fails++;
      $display("FAIL fwd_same_cycle_push: memreaddata=%h required dead", sb_if.memreaddata);
    end
    @(posedge clk);
    #1;
    sb_if.memwrite = 1'b0;
    #1;
    tests++;
    if (sb_if.memreaddata !== (FWD ? 32'h7 : 32'hDEAD)) begin
      fails++;
      $display("FAIL fwd_after_push: memreaddata=%h required %h", sb_if.memreaddata, FWD ? 32'h7 : 32'hDEAD);
    end
    drain();
  endtask
  task automatic test_reset_mid_drain();
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h300 + 4 * i, 32'h30 + i, 1'b0);
    sb_if.memwrite = 1'b0;
    #3;
    reset = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    tests++;
    if ({sb_if.empty, sb_if.dm_req} !== 2'b10) begin
      fails++;
      $display("FAIL reset_mid_drain: empty=%b req=%b required 1 0", sb_if.empty, sb_if.dm_req);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 32'h0, 1'b1);
    tests++;
    if (sb_if.empty !== 1'b1) begin
      fails++;
      $display("FAIL reset_discard: empty=%b required 1", sb_if.empty);
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), 32'h1000 + 4 * i, $urandom, 1'($urandom_range(0, 1)));
      tests++;
      if ({sb_if.full, sb_if.empty, sb_if.overflow} !== {exp_q.size() == DEPTH, exp_q.size() == 0, exp_ovf}) begin
        fails++;
        $display("FAIL b2b_status%0d: full/empty/ovf=%b required %b", i, {sb_if.full, sb_if.empty, sb_if.overflow}, {exp_q.size() == DEPTH, exp_q.size() == 0, exp_ovf});
      end
    end
    drain();
  endtask
  initial begin
    sb_if.memwrite = 1'b0;
    sb_if.memaddr = '0;
    sb_if.memwritedata = '0;
    sb_if.dm_rdata = '0;
    sb_if.dm_ack = 1'b0;
    test_reset();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_forward();
    test_reset_mid_drain();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end
endmodule
